// File: rtl/display_scanner.sv
// -----------------------------------------------------------------------------
// display_scanner
//
// Time-multiplexing scanner for an 8-digit seven-segment display. It sits
// directly in front of the 3-to-8 anode decoder.
//
// The scanner latches a 32-bit hex value. It steps a digit index through 0..7
// and advances once every PRESCALE clock cycles. For the current digit it
// drives the active-low segment glyph and a blank flag. The glyph and the
// blank flag are decoded only from registers, so no input reaches an output
// through combinational logic.
//
// Parameters
//   PRESCALE        clock cycles per digit slot (>= 1)
//
// Ports
//   clk             system clock, rising edge
//   reset_n         asynchronous active-low reset
//   value_in        [31:0] value to show; [31:28] is the leftmost digit
//   load_in         captures value_in at the next rising edge
//   enable_in       display enable (registered); low blanks every digit
//   blank_lz_in     leading-zero blanking request (registered)
//   digit_sel_out   [2:0] digit index, drives decoder d (0 = leftmost)
//   segments_out    [6:0] {g,f,e,d,c,b,a}, active-low
//   digit_blank_out high when the current digit must stay dark
//   tick_out        high in the last cycle of each digit slot
// -----------------------------------------------------------------------------
module display_scanner #(
    parameter int PRESCALE = 100000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] value_in,
    input  logic        load_in,
    input  logic        enable_in,
    input  logic        blank_lz_in,
    output logic [2:0]  digit_sel_out,
    output logic [6:0]  segments_out,
    output logic        digit_blank_out,
    output logic        tick_out
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    dig_q, dig_d;
    logic [31:0]   val_q, val_d;
    logic          en_q;
    logic          lz_q;

    logic          tick;
    logic [3:0]    nibs [8];
    logic [7:0]    zero_upto;
    logic [3:0]    cur_nib;
    logic          lz_blank;
    logic          blank;

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'h40;
            4'h1:    g = 7'h79;
            4'h2:    g = 7'h24;
            4'h3:    g = 7'h30;
            4'h4:    g = 7'h19;
            4'h5:    g = 7'h12;
            4'h6:    g = 7'h02;
            4'h7:    g = 7'h78;
            4'h8:    g = 7'h00;
            4'h9:    g = 7'h10;
            4'hA:    g = 7'h08;
            4'hB:    g = 7'h03;
            4'hC:    g = 7'h46;
            4'hD:    g = 7'h21;
            4'hE:    g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    // ------------------------------------------------------------------
    // Prescaler and digit counter
    // ------------------------------------------------------------------
    assign tick = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        dig_d = dig_q;
        if (tick) begin
            cnt_d = '0;
            dig_d = dig_q + 3'd1;
        end
    end

    always_comb begin
        val_d = val_q;
        if (load_in) begin
            val_d = value_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            dig_q <= 3'd0;
            val_q <= 32'd0;
            en_q  <= 1'b0;
            lz_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            dig_q <= dig_d;
            val_q <= val_d;
            en_q  <= enable_in;
            lz_q  <= blank_lz_in;
        end
    end

    // ------------------------------------------------------------------
    // Nibble selection and leading-zero detection
    // ------------------------------------------------------------------
    // The decoder maps index 0 to the leftmost anode, so index k selects the
    // k-th nibble counted from the MSB end.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            nibs[k] = val_q[31 - 4*k -: 4];
        end
    end

    // zero_upto[k] is set when every nibble from the leftmost one through
    // nibble k is zero.
    always_comb begin
        logic run;
        run = 1'b1;
        zero_upto = '0;
        for (int k = 0; k < 8; k++) begin
            run = run & (nibs[k] == 4'd0);
            zero_upto[k] = run;
        end
    end

    assign cur_nib = nibs[dig_q];

    // The rightmost digit is never suppressed, so a value of zero still
    // shows a single "0".
    assign lz_blank = lz_q && (dig_q != 3'd7) && zero_upto[dig_q];
    assign blank    = !en_q || lz_blank;

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign digit_sel_out   = dig_q;
    assign digit_blank_out = blank;
    assign segments_out    = blank ? 7'h7F : hex_glyph(cur_nib);
    assign tick_out        = tick;

endmodule

// File: tb/tb_display_scanner.sv
module tb_display_scanner;

    logic        clk;
    logic        reset_n;
    logic [31:0] value_in;
    logic        load_in;
    logic        enable_in;
    logic        blank_lz_in;

    logic [2:0]  sel_a, sel_b;
    logic [6:0]  seg_a, seg_b;
    logic        blank_a, blank_b;
    logic        tick_a, tick_b;

    int n_checks = 0;
    int n_fail   = 0;
    int n        = -1;   // edges since reset release, minus one

    display_scanner #(.PRESCALE(4)) dut_a (
        .clk(clk), .reset_n(reset_n), .value_in(value_in), .load_in(load_in),
        .enable_in(enable_in), .blank_lz_in(blank_lz_in),
        .digit_sel_out(sel_a), .segments_out(seg_a),
        .digit_blank_out(blank_a), .tick_out(tick_a));

    display_scanner #(.PRESCALE(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .value_in(value_in), .load_in(load_in),
        .enable_in(enable_in), .blank_lz_in(blank_lz_in),
        .digit_sel_out(sel_b), .segments_out(seg_b),
        .digit_blank_out(blank_b), .tick_out(tick_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected digit glyphs, written out by hand for each test value
    logic [6:0] exp_0123 [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
    logic [6:0] exp_89ab [8] = '{7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [6:0] exp_0a05 [8] = '{7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h40, 7'h12};
    logic       bl_0a05  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [6:0] exp_zero [8] = '{7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};
    logic       bl_zero  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        n++;
    endtask

    // Timing of the PRESCALE=4 instance after the first reset release
    function automatic int ea_cnt();
        return (1 + n) % 4;
    endfunction
    function automatic int ea_dig();
        return ((1 + n) / 4) % 8;
    endfunction

    initial begin
        reset_n     = 1'b0;
        value_in    = 32'd0;
        load_in     = 1'b0;
        enable_in   = 1'b0;
        blank_lz_in = 1'b0;

        #3;
        check("rst_sel",   32'(sel_a),   32'd0);
        check("rst_seg",   32'(seg_a),   32'h7F);
        check("rst_blank", 32'(blank_a), 32'd1);
        check("rst_tick",  32'(tick_a),  32'd0);
        check("rst_sel_b", 32'(sel_b),   32'd0);

        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        value_in  = 32'h0123_4567;
        load_in   = 1'b1;
        enable_in = 1'b1;
        step();
        load_in = 1'b0;

        // Scan rate and glyph order, both instances
        for (int i = 0; i < 35; i++) begin
            check("scan_sel",   32'(sel_a),   32'(ea_dig()));
            check("scan_tick",  32'(tick_a),  32'(ea_cnt() == 3));
            check("glyph1_seg", 32'(seg_a),   32'(exp_0123[ea_dig()]));
            check("glyph1_bl",  32'(blank_a), 32'd0);
            check("p1_sel",     32'(sel_b),   32'((1 + n) % 8));
            check("p1_tick",    32'(tick_b),  32'd1);
            check("p1_seg",     32'(seg_b),   32'(exp_0123[(1 + n) % 8]));
            step();
        end

        value_in = 32'h89AB_CDEF;
        load_in  = 1'b1;
        step();
        load_in = 1'b0;
        for (int i = 0; i < 32; i++) begin
            check("glyph2_seg", 32'(seg_a),   32'(exp_89ab[ea_dig()]));
            check("glyph2_bl",  32'(blank_a), 32'd0);
            step();
        end

        value_in    = 32'h0000_0A05;
        load_in     = 1'b1;
        blank_lz_in = 1'b1;
        step();
        load_in = 1'b0;
        for (int i = 0; i < 32; i++) begin
            check("lz_seg", 32'(seg_a),   32'(exp_0a05[ea_dig()]));
            check("lz_bl",  32'(blank_a), 32'(bl_0a05[ea_dig()]));
            step();
        end

        value_in = 32'd0;
        load_in  = 1'b1;
        step();
        load_in = 1'b0;
        for (int i = 0; i < 32; i++) begin
            check("lz0_seg", 32'(seg_a),   32'(exp_zero[ea_dig()]));
            check("lz0_bl",  32'(blank_a), 32'(bl_zero[ea_dig()]));
            step();
        end

        // Mid-scan load and disable
        value_in    = 32'h1111_1111;
        load_in     = 1'b1;
        blank_lz_in = 1'b0;
        step();
        load_in = 1'b0;
        for (int i = 0; i < 40 && !(ea_dig() == 3 && ea_cnt() == 0); i++) begin
            step();
        end
        check("mid_align", 32'(sel_a), 32'd3);
        check("mid_old",   32'(seg_a), 32'h79);
        value_in = 32'h0005_0000;
        load_in  = 1'b1;
        step();
        load_in = 1'b0;
        check("mid_sel",  32'(sel_a),   32'd3);
        check("mid_new",  32'(seg_a),   32'h12);
        check("mid_bl",   32'(blank_a), 32'd0);
        enable_in = 1'b0;
        step();
        check("dis_sel",  32'(sel_a),   32'd3);
        check("dis_seg",  32'(seg_a),   32'h7F);
        check("dis_bl",   32'(blank_a), 32'd1);
        step();
        check("dis_tick", 32'(tick_a),  32'd1);
        step();
        check("dis_adv",  32'(sel_a),   32'd4);
        check("dis_bl4",  32'(blank_a), 32'd1);

        // Asynchronous reset mid-scan
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_sel",   32'(sel_a),   32'd0);
        check("arst_seg",   32'(seg_a),   32'h7F);
        check("arst_blank", 32'(blank_a), 32'd1);
        check("arst_tick",  32'(tick_a),  32'd0);
        check("arst_sel_b", 32'(sel_b),   32'd0);
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        enable_in = 1'b1;
        step();
        check("rel_tick1", 32'(tick_a), 32'd0);
        step();
        check("rel_tick2", 32'(tick_a), 32'd0);
        step();
        check("rel_tick3", 32'(tick_a), 32'd1);
        check("rel_sel3",  32'(sel_a),  32'd0);
        check("rel_val",   32'(seg_a),  32'h40);
        step();
        check("rel_sel4",  32'(sel_a),  32'd1);
        check("rel_tick4", 32'(tick_a), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
